// File: rtl/vpm_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// vpm_pipe_ctrl
//   Control block for the five-stage I/M1/M2/M3/O pipeline. It owns the stage
//   valid bits and produces the stage register load enables and the I/M1
//   active-low clear strobes. Upstream and downstream use valid/ready
//   handshakes. Bubbles collapse: an empty stage accepts from the stage in
//   front of it even when later stages are blocked. M1 may flush I and M1,
//   and M2 may stall itself. Effective M2 stall cycles are counted in a
//   saturating counter.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous reset, active-high
//   in_valid    : upstream entry available
//   in_ready    : I stage accepts an entry this cycle
//   out_valid   : O stage holds a valid entry
//   out_ready   : downstream consumes the O entry
//   flush_req   : kill the I and M1 entries at this edge
//   stall_req   : hold the M2 entry this cycle
//   valid[4:0]  : registered stage valid bits, [0]=I .. [4]=O
//   en[4:0]     : combinational stage register load enables
//   flush_n_I   : active-low clear strobe for the I register
//   flush_n_M1  : active-low clear strobe for the M1 register
//   occ[2:0]    : registered number of valid stages (0..5)
//   stall_cnt   : saturating count of effective M2 stall cycles
// -----------------------------------------------------------------------------
module vpm_pipe_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush_req,
  input  logic                 stall_req,
  output logic [4:0]           valid,
  output logic [4:0]           en,
  output logic                 flush_n_I,
  output logic                 flush_n_M1,
  output logic [2:0]           occ,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  logic [4:0]           valid_q, valid_d;
  logic [2:0]           occ_q, occ_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic [4:0] hold;
  logic [4:0] adv;
  logic [4:0] rdy;
  logic       in_ready_c;
  logic       stall_inc;

  // Advance/ready chain. Evaluated from O back to I so that out_ready ripples
  // through every stage in the same cycle; there is no skid buffering.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    hold    = '0;
    hold[0] = flush_req;  // a flushed entry never moves forward
    hold[1] = flush_req;
    hold[2] = stall_req;

    adv    = '0;
    rdy    = '0;
    adv[4] = valid_q[4] & out_ready;
    rdy[4] = ~valid_q[4] | adv[4];
    for (int k = 3; k >= 0; k--) begin
      adv[k] = valid_q[k] & rdy[k+1] & ~hold[k];
      rdy[k] = ~valid_q[k] | adv[k];
    end

    in_ready_c = rdy[0] & ~flush_req & ~rst;
  end

  // Load enables are forced low during reset so no stage register captures
  // anything while the valid bits are being cleared.
  always_comb begin
    en = '0;
    if (!rst) begin
      en[0]   = in_valid & in_ready_c;
      en[4:1] = adv[3:0];
    end
  end

  // Next-state valid bits and their popcount.
  always_comb begin
    valid_d = '0;
    for (int k = 0; k < 5; k++) begin
      valid_d[k] = en[k] | (valid_q[k] & ~adv[k]);
    end
    // The flush wins over anything moving into I or M1 at this edge.
    if (flush_req) begin
      valid_d[1:0] = 2'b00;
    end

    occ_d = '0;
    for (int k = 0; k < 5; k++) begin
      occ_d = occ_d + {2'b00, valid_d[k]};
    end
  end

  // Only a real hold counts: M2 holds a valid entry that M3 could have taken.
  always_comb begin
    stall_inc   = stall_req & valid_q[2] & rdy[3];
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      occ_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign out_valid  = valid_q[4];
  assign valid      = valid_q;
  assign occ        = occ_q;
  assign stall_cnt  = stall_cnt_q;
  // The clear strobes follow flush_req directly, also during reset.
  assign flush_n_I  = ~flush_req;
  assign flush_n_M1 = ~flush_req;

endmodule

// File: tb/tb_vpm_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vpm_pipe_ctrl
//   Directed bench for vpm_pipe_ctrl. A default-width instance and a
//   CNT_WIDTH=4 instance share every input; the narrow one is used to check
//   counter saturation. Inputs change 1 time unit after the rising edge and
//   outputs are sampled 1 time unit later, away from the edge.
// -----------------------------------------------------------------------------
module tb_vpm_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        flush_req;
  logic        stall_req;

  logic        in_ready, out_valid, flush_n_I, flush_n_M1;
  logic [4:0]  valid, en;
  logic [2:0]  occ;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_flush_n_I, s_flush_n_M1;
  logic [4:0]  s_valid, s_en;
  logic [2:0]  s_occ;
  logic [3:0]  s_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out;

  always #5 clk = ~clk;

  vpm_pipe_ctrl #(.CNT_WIDTH(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_req  (flush_req),
    .stall_req  (stall_req),
    .valid      (valid),
    .en         (en),
    .flush_n_I  (flush_n_I),
    .flush_n_M1 (flush_n_M1),
    .occ        (occ),
    .stall_cnt  (stall_cnt)
  );

  vpm_pipe_ctrl #(.CNT_WIDTH(4)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .flush_req  (flush_req),
    .stall_req  (stall_req),
    .valid      (s_valid),
    .en         (s_en),
    .flush_n_I  (s_flush_n_I),
    .flush_n_M1 (s_flush_n_M1),
    .occ        (s_occ),
    .stall_cnt  (s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush_req = 1'b0; stall_req = 1'b0;

    // ---------------- reset ----------------
    repeat (3) tick();
    #1;
    check("rst_valid",    32'(valid),     32'h0);
    check("rst_occ",      32'(occ),       32'h0);
    check("rst_stallcnt", 32'(stall_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready),  32'h0);
    check("rst_en",       32'(en),        32'h0);
    flush_req = 1'b1;
    #1;
    check("rst_flush_n_I",  32'(flush_n_I),  32'h0);
    check("rst_flush_n_M1", 32'(flush_n_M1), 32'h0);
    flush_req = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // ---------------- streaming: 8 entries, out_ready=1 ----------------
    n_out = 0;
    for (int c = 0; c <= 14; c++) begin
      in_valid  = (c < 8);
      out_ready = 1'b1;
      #1;
      if (c < 8)   check("stream_in_ready", 32'(in_ready), 32'h1);
      if (c == 3)  check("stream_valid_c3", 32'(valid), 32'h07);
      if (c == 14) begin
        check("stream_valid_end", 32'(valid), 32'h0);
        check("stream_occ_end",   32'(occ),   32'h0);
      end
      check("stream_out_valid", 32'(out_valid), 32'((c >= 5) && (c <= 12)));
      if (out_valid && out_ready) n_out++;
      tick();
    end
    check("stream_n_out", 32'(n_out), 32'd8);

    // ---------------- backpressure ----------------
    n_out = 0;
    for (int c = 0; c <= 20; c++) begin
      in_valid  = (c <= 11);
      out_ready = !((c >= 3) && (c <= 7));
      #1;
      if (c == 4) check("bp_occ_c4", 32'(occ), 32'd4);
      if (c == 5) begin
        check("bp_valid_full", 32'(valid),    32'h1f);
        check("bp_occ_full",   32'(occ),      32'd5);
        check("bp_in_ready",   32'(in_ready), 32'h0);
        check("bp_en_full",    32'(en),       32'h0);
      end
      if (c == 7) begin
        check("bp_in_ready_c7", 32'(in_ready), 32'h0);
        check("bp_en_c7",       32'(en),       32'h0);
      end
      if (c == 8) begin
        check("bp_release_en",       32'(en),       32'h1f);
        check("bp_release_in_ready", 32'(in_ready), 32'h1);
      end
      if (c >= 8) check("bp_out_valid", 32'(out_valid), 32'(c <= 16));
      if (out_valid && out_ready) n_out++;
      tick();
    end
    check("bp_n_out", 32'(n_out), 32'd9);

    // ---------------- stall of 3 cycles on M2 ----------------
    n_out = 0;
    for (int c = 0; c <= 14; c++) begin
      in_valid  = (c <= 7);
      out_ready = 1'b1;
      stall_req = (c >= 3) && (c <= 5);
      #1;
      if ((c >= 3) && (c <= 5)) begin
        check("stall_valid_held", 32'(valid),    32'h07);
        check("stall_in_ready",   32'(in_ready), 32'h0);
        check("stall_en",         32'(en),       32'h0);
      end
      if (c == 4) check("stall_cnt_c4", 32'(stall_cnt), 32'd1);
      if (c == 6) begin
        check("stall_cnt_c6",   32'(stall_cnt), 32'd3);
        check("stall_en_c6",    32'(en),        32'h0f);
        check("stall_in_ready_c6", 32'(in_ready), 32'h1);
      end
      check("stall_out_valid", 32'(out_valid), 32'((c >= 8) && (c <= 12)));
      if (out_valid && out_ready) n_out++;
      tick();
    end
    stall_req = 1'b0;
    check("stall_n_out", 32'(n_out), 32'd5);

    // ---------------- flush on a full pipeline ----------------
    n_out = 0;
    for (int c = 0; c <= 13; c++) begin
      in_valid  = (c <= 7);
      out_ready = 1'b1;
      flush_req = (c == 5);
      #1;
      if (c == 5) begin
        check("flush_valid_full", 32'(valid),      32'h1f);
        check("flush_n_I_low",    32'(flush_n_I),  32'h0);
        check("flush_n_M1_low",   32'(flush_n_M1), 32'h0);
        check("flush_in_ready",   32'(in_ready),   32'h0);
        check("flush_en",         32'(en),         32'h18);
      end
      if (c == 6) begin
        check("flush_valid_after", 32'(valid),     32'h18);
        check("flush_occ_after",   32'(occ),       32'd2);
        check("flush_n_I_high",    32'(flush_n_I), 32'h1);
      end
      check("flush_out_valid", 32'(out_valid),
            32'(((c >= 5) && (c <= 7)) || ((c >= 11) && (c <= 12))));
      if ((c >= 5) && (c <= 10) && out_valid && out_ready) n_out++;
      tick();
    end
    flush_req = 1'b0;
    check("flush_n_out", 32'(n_out), 32'd3);

    // ---------------- flush together with stall ----------------
    for (int c = 0; c <= 7; c++) begin
      in_valid  = (c <= 2);
      out_ready = 1'b1;
      flush_req = (c == 3);
      stall_req = (c == 3);
      #1;
      if (c == 3) begin
        check("fs_valid",    32'(valid),     32'h07);
        check("fs_in_ready", 32'(in_ready),  32'h0);
        check("fs_en",       32'(en),        32'h0);
        check("fs_flush_n",  32'(flush_n_I), 32'h0);
      end
      if (c == 4) begin
        check("fs_valid_after", 32'(valid),     32'h04);
        check("fs_occ_after",   32'(occ),       32'd1);
        check("fs_stall_cnt",   32'(stall_cnt), 32'd4);
      end
      if (c == 5) check("fs_valid_c5", 32'(valid), 32'h08);
      if (c == 7) check("fs_valid_end", 32'(valid), 32'h0);
      tick();
    end
    flush_req = 1'b0;
    stall_req = 1'b0;

    // ---------------- reset while full ----------------
    for (int c = 0; c <= 4; c++) begin
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      tick();
    end
    #1;
    check("mr_valid_full", 32'(valid), 32'h1f);
    check("mr_occ_full",   32'(occ),   32'd5);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mr_en_in_rst",       32'(en),       32'h0);
    check("mr_in_ready_in_rst", 32'(in_ready), 32'h0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mr_valid",       32'(valid),       32'h0);
    check("mr_occ",         32'(occ),         32'h0);
    check("mr_stall_cnt",   32'(stall_cnt),   32'h0);
    check("mr_sat_cnt",     32'(s_stall_cnt), 32'h0);
    check("mr_sat_valid",   32'(s_valid),     32'h0);
    check("mr_out_valid",   32'(out_valid),   32'h0);

    // ---------------- saturation with a 20-cycle stall ----------------
    for (int c = 0; c <= 23; c++) begin
      in_valid  = (c <= 2);
      out_ready = 1'b1;
      stall_req = (c >= 3) && (c <= 22);
      #1;
      if (c == 18) check("sat_cnt_c18", 32'(s_stall_cnt), 32'd15);
      if (c == 19) begin
        check("sat_cnt_c19",  32'(s_stall_cnt), 32'd15);
        check("wide_cnt_c19", 32'(stall_cnt),   32'd16);
      end
      if (c == 23) begin
        check("sat_cnt_end",  32'(s_stall_cnt), 32'd15);
        check("wide_cnt_end", 32'(stall_cnt),   32'd20);
      end
      tick();
    end
    stall_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
